lsu_rmw_initiator: RTL and testbench

- Core-side initiator for the data port of the unified memory bus.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the core through a valid/ready handshake.
- Drives the word-only memory interface: combinational read, write committed at posedge when mem_we=1.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores. Returns a one-cycle response pulse.

---
 rtl/lsu_rmw_initiator.sv | 164 ++++++++++++++++
 tb/tb_lsu_rmw_initiator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw_initiator.sv
// Core-side load/store initiator for a word-only memory port: byte/half extraction for loads,
// read-modify-write for sub-word stores. Optional misalignment rejection under `LSU_MISALIGN_EN.
module lsu_rmw_initiator #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

`ifdef LSU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] word_q, word_d;
    logic            accept;
    logic            reject;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // funct3[1:0] encodes access size for every legal load/store: 01 = half, 10 = word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return MISALIGN_EN && (((f3[1:0] == 2'b01) && off[0]) ||
                               ((f3[1:0] == 2'b10) && (off != 2'b00)));
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            3'b010:  return w;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] w,
                                                    input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        r = w;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign reject    = is_illegal(we_q, funct3_q) || is_misaligned(funct3_q, addr_q[1:0]);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    // Only an aligned SW can skip the read; everything else reads first.
                    if (req_we && req_funct3 == 3'b010 && !is_misaligned(req_funct3, req_addr[1:0]))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                word_d = mem_rdata;
                if (we_q && !reject && funct3_q[2:1] == 2'b00)
                    state_d = S_WR;
                else
                    state_d = S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
        end
    end

    // Write strobe is gated by reset so an abandoned WR cycle never commits.
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_we    = (state_q == S_WR) && !reset;
    assign mem_wdata = (state_q == S_WR) ? store_merge(funct3_q, addr_q[1:0], word_q, wdata_q) : '0;

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid && reject;
    assign rsp_rdata = (rsp_valid && !we_q && !reject) ? load_extract(funct3_q, addr_q[1:0], word_q)
                                                       : '0;

endmodule

// File: tb/tb_lsu_rmw_initiator.sv
// Bench for lsu_rmw_initiator: directed vector table, reset-abort sequences, and random traffic
// checked against a word-array reference model of the load/store rules.
module tb_lsu_rmw_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:127];
    logic [31:0] ref_mem [0:127];
    logic        tb_we;
    logic [6:0]  tb_a;
    logic [31:0] tb_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_rmw_initiator #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr[8:2]] <= mem_wdata;
        else if (tb_we) mem[tb_a] <= tb_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: spec rules applied to a plain word array.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er, output int lat, output int wec);
        int unsigned idx, bsh, hsh;
        logic [31:0] w, b, h, mask;
        logic legal, mis;
        idx = a[8:2];
        w = ref_mem[idx];
        bsh = 8 * a[1:0];
        hsh = a[1] ? 16 : 0;
        b = (w >> bsh) & 32'hFF;
        h = (w >> hsh) & 32'hFFFF;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd3, 3'd6, 3'd7});
        mis = 1'b0;
`ifdef LSU_MISALIGN_EN
        mis = ((f3 == 3'd1 || (!we && f3 == 3'd5)) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`endif
        er = !legal || mis;
        rd = 32'h0;
        lat = 2;
        wec = -1;
        if (!er && !we) begin
            case (f3)
                3'd0: rd = b | (b[7] ? 32'hFFFFFF00 : 32'h0);
                3'd4: rd = b;
                3'd1: rd = h | (h[15] ? 32'hFFFF0000 : 32'h0);
                3'd5: rd = h;
                default: rd = w;
            endcase
        end else if (!er && we) begin
            if (f3 == 3'd2) begin
                wec = 1;
                ref_mem[idx] = wd;
            end else begin
                lat = 3;
                wec = 2;
                mask = (f3 == 3'd0) ? (32'hFF << bsh) : (32'hFFFF << hsh);
                ref_mem[idx] = (w & ~mask) | ((wd << ((f3 == 3'd0) ? bsh : hsh)) & mask);
            end
        end
    endfunction

    // Called at #1 after a posedge; returns at #1 after a posedge with the DUT idle.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wec, output int wn, output logic [31:0] ma);
        int waitc = 0;
        while (!req_ready && waitc < 8) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd = 32'h0; er = 1'b0; lat = -1; wec = -1; wn = 0; ma = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) ma = mem_addr;
            if (mem_we) begin
                wn++;
                if (wec < 0) wec = k;
            end
            if (rsp_valid && lat < 0) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wec;
    } vec_t;

    vec_t tbl[15];

    task automatic check_txn(input string tag, input logic [31:0] a,
                             input logic [31:0] rd, input logic er, input int lat, input int wec,
                             input int wn, input logic [31:0] ma,
                             input logic [31:0] erd, input logic eer, input int elat, input int ewec);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, eer});
        chk({tag, "_rsp_cycle"}, 32'(lat), 32'(elat));
        chk({tag, "_we_cycle"}, 32'(wec), 32'(ewec));
        chk({tag, "_we_count"}, 32'(wn), (ewec < 0) ? 32'd0 : 32'd1);
        chk({tag, "_mem_addr"}, ma, {a[31:2], 2'b00});
        chk({tag, "_mem_word"}, mem[a[8:2]], ref_mem[a[8:2]]);
    endtask

    initial begin
        logic [31:0] rd, mrd, ma;
        logic        er, mer;
        int          lat, wec, wn, mlat, mwec, cnt;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra, rwd;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; tb_we = 1'b0; tb_a = 7'd0; tb_d = 32'h0;
        for (int i = 0; i < 128; i++) begin
            tb_we = 1'b1; tb_a = 7'(i); tb_d = (i == 64) ? 32'h8077F0A5 : 32'h0;
            ref_mem[i] = tb_d;
            @(posedge clk); #1;
        end
        tb_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        tbl[0]  = '{1'b0, 3'd0, 32'h100, 32'h0,        32'hFFFFFFA5, 1'b0, 2, -1};
        tbl[1]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h00000080, 1'b0, 2, -1};
        tbl[2]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFF8077, 1'b0, 2, -1};
        tbl[3]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h0000F0A5, 1'b0, 2, -1};
`ifdef LSU_MISALIGN_EN
        tbl[4]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h00000000, 1'b1, 2, -1};
`else
        tbl[4]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h8077F0A5, 1'b0, 2, -1};
`endif
        tbl[5]  = '{1'b1, 3'd0, 32'h101, 32'h12,       32'h0,        1'b0, 3, 2};
        tbl[6]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h807712A5, 1'b0, 2, -1};
        tbl[7]  = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        tbl[8]  = '{1'b0, 3'd2, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 2, -1};
        tbl[9]  = '{1'b1, 3'd3, 32'h104, 32'h11111111, 32'h0,        1'b1, 2, -1};
        tbl[10] = '{1'b0, 3'd2, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 2, -1};
        tbl[11] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, 2, -1};
        tbl[12] = '{1'b1, 3'd1, 32'h102, 32'h5566,     32'h0,        1'b0, 3, 2};
        tbl[13] = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h00005566, 1'b0, 2, -1};
        tbl[14] = '{1'b0, 3'd4, 32'h102, 32'h0,        32'h00000066, 1'b0, 2, -1};

        for (int i = 0; i < 15; i++) begin
            run(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, lat, wec, wn, ma);
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, mrd, mer, mlat, mwec);
            check_txn($sformatf("vec%0d", i), tbl[i].addr, rd, er, lat, wec, wn, ma,
                      tbl[i].rd, tbl[i].er, tbl[i].lat, tbl[i].wec);
        end

        // Reset during the RD cycle of an SH: transaction abandoned.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h106; req_wdata = 32'hCAFE;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        cnt = 0;
        @(negedge clk);
        if (mem_we || rsp_valid) cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("shrst_ready_after", {31'b0, req_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (mem_we || rsp_valid) cnt++;
            @(negedge clk);
        end
        chk("shrst_no_activity", 32'(cnt), 32'd0);
        chk("shrst_word104", mem[65], 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset coinciding with the WR cycle of an SW: write strobe suppressed.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h104; req_wdata = 32'h01234567;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("swrst_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("swrst_word104", mem[65], 32'hDEADBEEF);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) cnt++;
        end
        chk("swrst_no_activity", 32'(cnt), 32'd0);
        chk("swrst_ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = 32'($urandom_range(0, 511));
            rwd = $urandom;
            run(rwe, rf3, ra, rwd, rd, er, lat, wec, wn, ma);
            model(rwe, rf3, ra, rwd, mrd, mer, mlat, mwec);
            check_txn($sformatf("rnd%0d", i), ra, rd, er, lat, wec, wn, ma, mrd, mer, mlat, mwec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
